// File: rtl/alu_mode_sequencer.sv
// alu_mode_sequencer: button-driven controller for a 4-bit ALU datapath.
// Debounces selector_n/start_n, steps the mode, latches operands, registers
// result plus C/N/Z/V, and raises show while the result is on display.
// Ports: clk, reset (async, high), selector_n/start_n (async buttons, low),
//   A/B operands, alu_result/alu_cout from datapath; alu_mode, op_a, op_b,
//   result, flag_c/n/z/v, busy (LATCH/EXEC), show (SHOW).
module alu_mode_sequencer #(
    parameter int N               = 4,
    parameter int NUM_MODES       = 10,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         selector_n,
    input  logic         start_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] alu_result,
    input  logic         alu_cout,
    output logic [3:0]   alu_mode,
    output logic [N-1:0] op_a,
    output logic [N-1:0] op_b,
    output logic [N-1:0] result,
    output logic         flag_c,
    output logic         flag_n,
    output logic         flag_z,
    output logic         flag_v,
    output logic         busy,
    output logic         show
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] MODE_LAST = 4'(NUM_MODES - 1);

    localparam logic [1:0] S_SELECT = 2'd0;
    localparam logic [1:0] S_LATCH  = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_SHOW   = 2'd3;

    // Bit 0 is the selector button, bit 1 the start button.
    logic [1:0]         r_sync1;
    logic [1:0]         r_sync2;
    logic [1:0]         r_db;
    logic [1:0]         r_pulse;
    logic [1:0][CW-1:0] r_cnt;

    logic [1:0]   r_state;
    logic [3:0]   r_mode;
    logic [N-1:0] r_op_a;
    logic [N-1:0] r_op_b;
    logic [N-1:0] r_result;
    logic         r_c;
    logic         r_n;
    logic         r_z;
    logic         r_v;

    logic         w_sel_p;
    logic         w_start_p;
    logic [3:0]   w_next_mode;
    logic         w_zero;
    logic [N-1:0] w_res;
    logic         w_c;
    logic         w_n;
    logic         w_z;
    logic         w_v;

    // Levels reset to released so no press edge can appear after reset.
    // A level is accepted once the synced input has differed from it for
    // DEBOUNCE_CYCLES samples in a row; a press (1->0) emits one pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
            r_db    <= 2'b11;
            r_pulse <= 2'b00;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= {start_n, selector_n};
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                r_pulse[i] <= 1'b0;
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_cnt[i]   <= '0;
                    r_db[i]    <= r_sync2[i];
                    r_pulse[i] <= ~r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_sel_p     = r_pulse[0];
    assign w_start_p   = r_pulse[1];
    assign w_next_mode = (r_mode == MODE_LAST) ? 4'd0 : r_mode + 4'd1;
    assign w_zero      = (alu_result == '0);

    // Result/flag selection for the EXEC capture; modes 2..4 are reserved
    // and always report zero with every flag clear.
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_n   = 1'b0;
        w_z   = 1'b0;
        w_v   = 1'b0;
        if (r_mode == 4'd0) begin
            w_res = alu_result;
            w_c   = alu_cout;
            w_z   = w_zero;
            w_v   = (r_op_a[N-1] == r_op_b[N-1]) &&
                    (alu_result[N-1] != r_op_a[N-1]);
        end else if (r_mode == 4'd1) begin
            w_res = alu_result;
            w_n   = alu_cout;
            w_z   = w_zero;
            w_v   = (r_op_a[N-1] != r_op_b[N-1]) &&
                    (alu_result[N-1] != r_op_a[N-1]);
        end else if (r_mode >= 4'd5) begin
            w_res = alu_result;
            w_z   = w_zero;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_SELECT;
            r_mode   <= 4'd0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_c      <= 1'b0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            case (r_state)
                S_SELECT: begin
                    if (w_start_p) begin
                        r_state <= S_LATCH;
                    end else if (w_sel_p) begin
                        r_mode <= w_next_mode;
                    end
                end
                S_LATCH: begin
                    r_op_a  <= A;
                    r_op_b  <= B;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_result <= w_res;
                    r_c      <= w_c;
                    r_n      <= w_n;
                    r_z      <= w_z;
                    r_v      <= w_v;
                    r_state  <= S_SHOW;
                end
                S_SHOW: begin
                    if (w_start_p) begin
                        r_state <= S_LATCH;
                    end else if (w_sel_p) begin
                        r_state  <= S_SELECT;
                        r_mode   <= w_next_mode;
                        r_result <= '0;
                        r_c      <= 1'b0;
                        r_n      <= 1'b0;
                        r_z      <= 1'b0;
                        r_v      <= 1'b0;
                    end
                end
                default: r_state <= S_SELECT;
            endcase
        end
    end

    assign alu_mode = r_mode;
    assign op_a     = r_op_a;
    assign op_b     = r_op_b;
    assign result   = r_result;
    assign flag_c   = r_c;
    assign flag_n   = r_n;
    assign flag_z   = r_z;
    assign flag_v   = r_v;
    assign busy     = (r_state == S_LATCH) || (r_state == S_EXEC);
    assign show     = (r_state == S_SHOW);

endmodule

// File: tb/tb_alu_mode_sequencer.sv
// tb_alu_mode_sequencer: random button stimulus, behavioural datapath and
// result model, scoreboard queue popped by a monitor when show rises.
module tb_alu_mode_sequencer;
    localparam int N  = 4;
    localparam int NM = 10;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         selector_n;
    logic         start_n;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] alu_result;
    logic         alu_cout;
    logic [3:0]   alu_mode;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [N-1:0] result;
    logic         flag_c;
    logic         flag_n;
    logic         flag_z;
    logic         flag_v;
    logic         busy;
    logic         show;

    alu_mode_sequencer #(
        .N(N), .NUM_MODES(NM), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .reset(reset),
        .selector_n(selector_n), .start_n(start_n),
        .A(A), .B(B),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .alu_mode(alu_mode), .op_a(op_a), .op_b(op_b),
        .result(result),
        .flag_c(flag_c), .flag_n(flag_n),
        .flag_z(flag_z), .flag_v(flag_v),
        .busy(busy), .show(show)
    );

    always #5 clk = ~clk;

    // Datapath stand-in; reserved modes drive junk the DUT must ignore.
    always_comb begin
        alu_result = 4'h0;
        alu_cout   = 1'b0;
        case (alu_mode)
            4'd0: {alu_cout, alu_result} = {1'b0, op_a} + {1'b0, op_b};
            4'd1: begin
                alu_result = op_a - op_b;
                alu_cout   = (op_a < op_b);
            end
            4'd5: alu_result = op_a & op_b;
            4'd6: alu_result = op_a | op_b;
            4'd7: alu_result = op_a ^ op_b;
            4'd8: alu_result = op_a << 1;
            4'd9: alu_result = op_a >> 1;
            default: begin
                alu_result = op_a ^ op_b ^ 4'h5;
                alu_cout   = 1'b1;
            end
        endcase
    end

    typedef struct {
        int mode;
        int res;
        int c;
        int n;
        int z;
        int v;
    } exp_t;

    exp_t q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   m_mode    = 0;
    bit   busy_seen = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int sgn(input int x);
        return (x > 7) ? x - 16 : x;
    endfunction

    function automatic exp_t model(input int m, input int a, input int b);
        exp_t e;
        int   s;
        e.mode = m;
        e.res = 0; e.c = 0; e.n = 0; e.z = 0; e.v = 0;
        case (m)
            0: begin
                e.res = (a + b) % 16;
                e.c   = (a + b > 15);
                s     = sgn(a) + sgn(b);
                e.v   = (s > 7 || s < -8);
            end
            1: begin
                e.res = (a - b + 16) % 16;
                e.n   = (a < b);
                s     = sgn(a) - sgn(b);
                e.v   = (s > 7 || s < -8);
            end
            5: e.res = a & b;
            6: e.res = a | b;
            7: e.res = a ^ b;
            8: e.res = (a * 2) % 16;
            9: e.res = a / 2;
            default: e.res = 0;
        endcase
        if (m < 2 || m > 4) e.z = (e.res == 0);
        return e;
    endfunction

    // Monitor: busy runs for exactly two cycles and each show rise
    // is matched against the oldest expected result.
    int busy_cnt  = 0;
    bit prev_show = 1'b0;
    bit prev_busy = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt  = 0;
            prev_show = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (busy) begin
                busy_cnt++;
                busy_seen = 1'b1;
            end else if (busy_cnt != 0) begin
                chk("busy_len", busy_cnt, 2);
                busy_cnt = 0;
            end
            if (show && !prev_show) begin
                chk("show_after_busy", prev_busy, 1);
                chk("show_pending", q.size() != 0, 1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("mode", alu_mode, e.mode);
                    chk("result", result, e.res);
                    chk("flag_c", flag_c, e.c);
                    chk("flag_n", flag_n, e.n);
                    chk("flag_z", flag_z, e.z);
                    chk("flag_v", flag_v, e.v);
                end
            end
            prev_show = show;
            prev_busy = busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input bit s, input bit t);
        selector_n = ~s;
        start_n    = ~t;
        tick(10);
        selector_n = 1'b1;
        start_n    = 1'b1;
        tick(10);
    endtask

    task automatic do_sel();
        press(1'b1, 1'b0);
        m_mode = (m_mode + 1) % NM;
        chk("sel_mode", alu_mode, m_mode);
        chk("sel_show", show, 0);
        chk("sel_clear", {result, flag_c, flag_n, flag_z, flag_v}, 0);
    endtask

    task automatic do_start(input int a, input int b, input bit with_sel);
        A = 4'(a);
        B = 4'(b);
        q.push_back(model(m_mode, a, b));
        press(with_sel, 1'b1);
        chk("start_show", show, 1);
        chk("start_busy", busy, 0);
        chk("start_mode", alu_mode, m_mode);
        chk("start_drained", q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset      = 1'b1;
        selector_n = 1'b1;
        start_n    = 1'b1;
        A          = '0;
        B          = '0;
        tick(3);
        chk("rst_mode", alu_mode, 0);
        chk("rst_outs", {op_a, op_b, result, flag_c, flag_n, flag_z,
                         flag_v, busy, show}, 0);
        reset = 1'b0;
        tick(20);
        chk("rst_release", {alu_mode, busy, show}, 0);

        for (int i = 0; i < 10; i++) do_sel();

        start_n = 1'b0;
        tick(3);
        start_n = 1'b1;
        tick(15);
        chk("short_busy", busy_seen, 0);
        chk("short_state", {show, alu_mode}, 0);

        do_start(4'h9, 4'h8, 1'b0);
        chk("dir_add_res", {result, flag_c, flag_v, flag_z, flag_n},
            {4'h1, 4'b1100});
        do_sel();
        do_start(3, 5, 1'b0);
        chk("dir_sub_res", {result, flag_n, flag_v, flag_z},
            {4'hE, 3'b100});
        repeat (4) do_sel();
        do_start(4'hA, 4'h5, 1'b0);
        chk("dir_and_z", {result, flag_z}, {4'h0, 1'b1});
        do_sel();
        do_start(4'h7, 4'h2, 1'b1);
        do_start(4'h3, 4'hC, 1'b1);

        for (int it = 0; it < 24; it++) begin
            k = $urandom_range(0, 3);
            repeat (k) do_sel();
            do_start($urandom_range(0, 15), $urandom_range(0, 15),
                     1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1)
                do_start($urandom_range(0, 15), $urandom_range(0, 15),
                         1'b0);
        end

        A       = 4'h6;
        B       = 4'h3;
        start_n = 1'b0;
        k       = 0;
        while (!busy && k < 40) begin
            tick(1);
            k++;
        end
        chk("mid_busy", busy, 1);
        tick(1);
        chk("mid_exec", {busy, show}, 2'b10);
        reset = 1'b1;
        #1;
        chk("mid_rst_mode", alu_mode, 0);
        chk("mid_rst_outs", {op_a, op_b, result, flag_c, flag_n, flag_z,
                             flag_v, busy, show}, 0);
        start_n = 1'b1;
        tick(3);
        reset     = 1'b0;
        busy_seen = 1'b0;
        m_mode    = 0;
        tick(25);
        chk("post_rst", {alu_mode, busy, show, busy_seen}, 0);
        chk("final_queue", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
